// File: rtl/bist_pkg.sv
// Shared types and constants for the vector BIST controller and its error tracker.
package bist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StApply,
        StWait,
        StCheck,
        StDone
    } bist_state_t;

    localparam int ERR_CNT_W = 16;

    // Field slices of the default 20-bit {A, B, Y_expected} vector record
    localparam int DEF_A_W = 8;
    localparam int DEF_B_W = 4;
    localparam int DEF_Y_W = 8;
    localparam int Y_LO    = 0;
    localparam int Y_HI    = Y_LO + DEF_Y_W - 1;
    localparam int B_LO    = Y_HI + 1;
    localparam int B_HI    = B_LO + DEF_B_W - 1;
    localparam int A_LO    = B_HI + 1;
    localparam int A_HI    = A_LO + DEF_A_W - 1;

endpackage

// File: rtl/bist_err_tracker.sv
// Saturating mismatch counter, first-error capture and one-cycle error pulse.
module bist_err_tracker
    import bist_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 check_en,
    input  logic                 mismatch,
    input  logic [ADDR_W-1:0]    idx,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    first_err_idx,
    output logic                 first_err_valid
);

    logic hit;
    assign hit = check_en && mismatch;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            err_pulse       <= 1'b0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            err_pulse <= hit;
            if (hit) begin
                if (err_count != '1) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
                if (!first_err_valid) begin
                    first_err_idx   <= idx;
                    first_err_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vector_bist_ctrl.sv
// Steps a synchronous vector ROM of {A, B, Y_expected} records through the DUT and
// reports mismatches.
module vector_bist_ctrl
    import bist_pkg::*;
#(
    parameter int A_W     = 8,
    parameter int B_W     = 4,
    parameter int Y_W     = 8,
    parameter int VEC_W   = 20,
    parameter int NUM_VEC = 70,
    parameter int ADDR_W  = 7,
    parameter int DUT_LAT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [ADDR_W-1:0]    vec_addr,
    input  logic [VEC_W-1:0]     vec_data,
    output logic [A_W-1:0]       dut_a,
    output logic [B_W-1:0]       dut_b,
    input  logic [Y_W-1:0]       dut_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    first_err_idx,
    output logic                 first_err_valid
);

    localparam int Y_MSB = Y_W - 1;
    localparam int B_LSB = Y_W;
    localparam int B_MSB = Y_W + B_W - 1;
    localparam int A_LSB = Y_W + B_W;
    localparam int A_MSB = VEC_W - 1;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'((NUM_VEC == 0) ? 0 : NUM_VEC - 1);
    localparam logic [2:0]        WAIT_LOAD = 3'((DUT_LAT == 0) ? 0 : DUT_LAT - 1);

    bist_state_t       state;
    logic [ADDR_W-1:0] idx;
    logic [2:0]        wait_cnt;
    logic [Y_W-1:0]    exp_y;
    logic              mismatch;
    logic              check_en;
    logic              clear;

    assign mismatch = (dut_y != exp_y);
    assign check_en = (state == StCheck);
    // Results clear on the same edge a run is accepted, from IDLE or DONE
    assign clear    = start && ((state == StIdle) || (state == StDone));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= StIdle;
            idx      <= '0;
            wait_cnt <= '0;
            exp_y    <= '0;
            vec_addr <= '0;
            dut_a    <= '0;
            dut_b    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        idx      <= '0;
                        vec_addr <= '0;
                        if (NUM_VEC == 0) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= StFetch;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
                StFetch: state <= StApply;
                StApply: begin
                    dut_a <= vec_data[A_MSB:A_LSB];
                    dut_b <= vec_data[B_MSB:B_LSB];
                    exp_y <= vec_data[Y_MSB:0];
                    if (DUT_LAT > 0) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= StWait;
                    end else begin
                        state <= StCheck;
                    end
                end
                StWait: begin
                    if (wait_cnt == 3'd0) begin
                        state <= StCheck;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                StCheck: begin
                    if (idx == LAST_IDX) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // The tracker updates on this same edge, so fold in this vector
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        idx      <= idx + ADDR_W'(1);
                        vec_addr <= idx + ADDR_W'(1);
                        state    <= StFetch;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    bist_err_tracker #(
        .ADDR_W(ADDR_W)
    ) u_err_tracker (
        .clk             (clk),
        .reset           (reset),
        .clear           (clear),
        .check_en        (check_en),
        .mismatch        (mismatch),
        .idx             (idx),
        .err_pulse       (err_pulse),
        .err_count       (err_count),
        .first_err_idx   (first_err_idx),
        .first_err_valid (first_err_valid)
    );

endmodule

// File: tb/tb_vector_bist_ctrl.sv
// Directed-sequence bench for vector_bist_ctrl over several parameterisations, with
// random ROM contents checked against a reference model of the vector run.
module tb_vector_bist_ctrl;
    import bist_pkg::*;

    localparam int NI = 5;
    // 0: main, 1: latency-2 DUT, 2: latency-2 DUT under a latency-0 controller,
    // 3: empty run, 4: 127-vector all-mismatch run
    localparam int NV   [NI] = '{70, 70, 70, 0, 127};
    localparam int LT   [NI] = '{0, 2, 0, 0, 0};
    localparam bit PIPE [NI] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rst_main;
    logic [NI-1:0] start_v, busy_v, done_v, pass_v, pulse_v, fev_v;
    logic [6:0]    vaddr [NI];
    logic [7:0]    da    [NI];
    logic [3:0]    db    [NI];
    logic [15:0]   cnt   [NI];
    logic [6:0]    fidx  [NI];
    logic [19:0]   rom   [NI][128];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    function automatic logic [7:0] f(input logic [7:0] a, input logic [3:0] b);
        return a + {{4{b[3]}}, b};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic       rst_g;
        logic [19:0] vdata;
        logic [7:0] dy, s1, s2;
        assign rst_g = (g == 0) ? rst_main : rst;
        always @(posedge clk) begin
            vdata <= rom[g][vaddr[g]];
            if (!rst_g) begin
                s1 <= 8'h00;
                s2 <= 8'h00;
            end else begin
                s1 <= f(da[g], db[g]);
                s2 <= s1;
            end
        end
        assign dy = PIPE[g] ? s2 : f(da[g], db[g]);

        vector_bist_ctrl #(
            .NUM_VEC(NV[g]),
            .DUT_LAT(LT[g])
        ) u_dut (
            .clk             (clk),
            .reset           (rst_g),
            .start           (start_v[g]),
            .vec_addr        (vaddr[g]),
            .vec_data        (vdata),
            .dut_a           (da[g]),
            .dut_b           (db[g]),
            .dut_y           (dy),
            .busy            (busy_v[g]),
            .done            (done_v[g]),
            .pass            (pass_v[g]),
            .err_pulse       (pulse_v[g]),
            .err_count       (cnt[g]),
            .first_err_idx   (fidx[g]),
            .first_err_valid (fev_v[g])
        );
    end

    logic        t_clear, t_en, t_mis, t_pulse, t_fev;
    logic [6:0]  t_idx, t_fidx;
    logic [15:0] t_cnt;

    bist_err_tracker #(
        .ADDR_W(7)
    ) u_trk (
        .clk             (clk),
        .reset           (rst),
        .clear           (t_clear),
        .check_en        (t_en),
        .mismatch        (t_mis),
        .idx             (t_idx),
        .err_pulse       (t_pulse),
        .err_count       (t_cnt),
        .first_err_idx   (t_fidx),
        .first_err_valid (t_fev)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int g, input bit bad);
        for (int i = 0; i < 128; i++) begin
            logic [7:0] a;
            logic [3:0] b;
            a = 8'($urandom);
            b = 4'($urandom);
            rom[g][i] = {a, b, f(a, b) ^ (bad ? 8'h5A : 8'h00)};
        end
    endtask

    // Each vector is judged against the DUT result for the vector `shift` places earlier
    // (the empty slot before vector 0 holds the reset operands 0/0).
    function automatic int model_errs(input int g, input int nv, input int shift);
        int n = 0;
        for (int i = 0; i < nv; i++) begin
            logic [7:0] y;
            if (i - shift < 0) y = f(8'h00, 4'h0);
            else y = f(rom[g][i-shift][19:12], rom[g][i-shift][11:8]);
            if (rom[g][i][7:0] != y) n++;
        end
        return n;
    endfunction

    function automatic int model_first(input int g, input int nv);
        for (int i = 0; i < nv; i++)
            if (rom[g][i][7:0] != f(rom[g][i][19:12], rom[g][i][11:8])) return i;
        return 0;
    endfunction

    task automatic run_inst(input int g, input bit hold, output int edges, output int busy_n,
                            output int pulses, output logic d0, output logic [15:0] c0);
        @(negedge clk);
        start_v[g] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_v[g] = 1'b0;
        d0     = done_v[g];
        c0     = cnt[g];
        busy_n = busy_v[g] ? 1 : 0;
        pulses = 0;
        edges  = 0;
        while (edges < 2000) begin
            @(posedge clk);
            #1;
            edges++;
            if (pulse_v[g]) pulses++;
            if (done_v[g]) break;
            if (busy_v[g]) busy_n++;
        end
        start_v[g] = 1'b0;
    endtask

    int          e, bn, pc, ne;
    logic        d0;
    logic [15:0] c0;

    initial begin
        rst      = 1'b0;
        rst_main = 1'b0;
        start_v  = '0;
        t_clear  = 1'b0;
        t_en     = 1'b0;
        t_mis    = 1'b0;
        t_idx    = 7'd0;
        for (int g = 0; g < NI; g++) fill(g, g == 4);
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", 32'({busy_v[0], done_v[0], pass_v[0], pulse_v[0], fev_v[0]}), 0);
        check("reset_count", 32'(cnt[0]), 0);
        check("reset_regs", 32'({vaddr[0], da[0], db[0], fidx[0]}), 0);
        @(negedge clk);
        rst      = 1'b1;
        rst_main = 1'b1;

        // All-correct run
        run_inst(0, 1'b0, e, bn, pc, d0, c0);
        check("clean_done_edge", 32'(e), 210);
        check("clean_busy_cycles", 32'(bn), 210);
        check("clean_pass", 32'(pass_v[0]), 1);
        check("clean_count", 32'(cnt[0]), 0);
        check("clean_first_valid", 32'(fev_v[0]), 0);
        check("clean_pulses", 32'(pc), 0);
        check("clean_hold_a", 32'(da[0]), 32'(rom[0][69][19:12]));
        check("clean_hold_b", 32'(db[0]), 32'(rom[0][69][11:8]));

        // Injected errors at 5 and 41, restarted from DONE
        rom[0][5][7:0]  = rom[0][5][7:0] ^ 8'h5A;
        rom[0][41][7:0] = rom[0][41][7:0] ^ 8'h81;
        ne = model_errs(0, 70, 0);
        run_inst(0, 1'b0, e, bn, pc, d0, c0);
        check("restart_clears_done", 32'(d0), 0);
        check("inj_done_edge", 32'(e), 210);
        check("inj_count", 32'(cnt[0]), 32'(ne));
        check("inj_pulses", 32'(pc), 32'(ne));
        check("inj_first_idx", 32'(fidx[0]), 32'(model_first(0, 70)));
        check("inj_first_valid", 32'(fev_v[0]), 1);
        check("inj_pass", 32'(pass_v[0]), 0);

        // start held through the run is ignored; identical result
        run_inst(0, 1'b1, e, bn, pc, d0, c0);
        check("hold_restart_clears", 32'(c0), 0);
        check("hold_done_edge", 32'(e), 210);
        check("hold_count", 32'(cnt[0]), 32'(ne));
        check("hold_first_idx", 32'(fidx[0]), 5);

        // Reset mid-run
        fill(0, 1'b0);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk);
        rst_main = 1'b0;
        @(posedge clk);
        #1;
        check("abort_flags", 32'({busy_v[0], done_v[0], pass_v[0], pulse_v[0], fev_v[0]}), 0);
        check("abort_count", 32'(cnt[0]), 0);
        check("abort_regs", 32'({vaddr[0], da[0], db[0], fidx[0]}), 0);
        @(negedge clk);
        rst_main = 1'b1;
        run_inst(0, 1'b0, e, bn, pc, d0, c0);
        check("post_abort_edge", 32'(e), 210);
        check("post_abort_pass", 32'(pass_v[0]), 1);

        // Latency-2 DUT, matched controller
        run_inst(1, 1'b0, e, bn, pc, d0, c0);
        check("lat2_done_edge", 32'(e), 350);
        check("lat2_pass", 32'(pass_v[1]), 1);
        check("lat2_count", 32'(cnt[1]), 0);

        // Latency-2 DUT, latency-0 controller: compared one vector stale
        rom[2] = rom[1];
        ne = model_errs(2, 70, 1);
        run_inst(2, 1'b0, e, bn, pc, d0, c0);
        check("latmis_done_edge", 32'(e), 210);
        check("latmis_count", 32'(cnt[2]), 32'(ne));
        check("latmis_pass", 32'(pass_v[2]), (ne == 0) ? 1 : 0);

        // Empty run
        run_inst(3, 1'b0, e, bn, pc, d0, c0);
        check("zero_done_next_edge", 32'(d0), 1);
        check("zero_pass", 32'(pass_v[3]), 1);
        check("zero_busy", 32'(bn), 0);

        // 127 vectors, all mismatching
        run_inst(4, 1'b0, e, bn, pc, d0, c0);
        check("full_done_edge", 32'(e), 381);
        check("full_count", 32'(cnt[4]), 127);
        check("full_pulses", 32'(pc), 127);
        check("full_first_idx", 32'(fidx[4]), 0);
        check("full_pass", 32'(pass_v[4]), 0);

        // Counter saturation on the tracker alone
        @(negedge clk);
        t_clear = 1'b1;
        @(negedge clk);
        t_clear = 1'b0;
        t_en    = 1'b1;
        t_mis   = 1'b1;
        t_idx   = 7'd9;
        @(negedge clk);
        t_idx = 7'd3;
        repeat (65533) @(negedge clk);
        check("sat_below", 32'(t_cnt), 32'hFFFE);
        check("sat_first_idx", 32'(t_fidx), 9);
        repeat (3) @(negedge clk);
        check("sat_hold", 32'(t_cnt), 32'hFFFF);
        check("sat_pulse", 32'(t_pulse), 1);
        t_en = 1'b0;
        @(negedge clk);
        check("sat_pulse_off", 32'(t_pulse), 0);
        check("sat_stays", 32'(t_cnt), 32'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
